// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one combinational ALU between two requesters. Requests are granted
// round-robin in IDLE, the decoded one-hot ALU controls and operands are
// driven for exactly one EXEC cycle, and the ALU result is registered and
// returned on a single response channel in RESP, tagged with the owner id.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   reqN_valid/ready             request handshake for requester N (0, 1)
//   reqN_op                      3-bit opcode (0 add .. 7 srl)
//   reqN_operand_1/2             request operands
//   alu_operation_*              one-hot ALU controls, high only in EXEC
//   alu_operand_1/2              ALU operands, non-zero only in EXEC
//   alu_result                   combinational ALU result
//   rsp_valid/ready              response handshake
//   rsp_id                       requester that owns the response
//   rsp_result                   registered ALU result

`ifndef X_LENGTH
`define X_LENGTH 32
`endif

module alu_arbiter #(
  parameter int unsigned X_LEN = `X_LENGTH
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [X_LEN-1:0] req0_operand_1,
  input  logic [X_LEN-1:0] req0_operand_2,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [X_LEN-1:0] req1_operand_1,
  input  logic [X_LEN-1:0] req1_operand_2,

  output logic             alu_operation_add,
  output logic             alu_operation_subtract,
  output logic             alu_operation_and,
  output logic             alu_operation_or,
  output logic             alu_operation_xor,
  output logic             alu_operation_shift_left_logical,
  output logic             alu_operation_shift_right_arithmetic,
  output logic             alu_operation_shift_right_logical,
  output logic [X_LEN-1:0] alu_operand_1,
  output logic [X_LEN-1:0] alu_operand_2,
  input  logic [X_LEN-1:0] alu_result,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [X_LEN-1:0] rsp_result
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t           state;
  logic             last_grant;  // 1: requester 1 won the most recent grant
  logic [7:0]       op_onehot;   // bit index equals opcode
  logic [X_LEN-1:0] opnd1_q;
  logic [X_LEN-1:0] opnd2_q;
  logic             grant0;
  logic             grant1;

  function automatic logic [7:0] decode_op(input logic [2:0] op);
    logic [7:0] d;
    d     = '0;
    d[op] = 1'b1;
    return d;
  endfunction

  // Grants are only offered in IDLE and never while reset is asserted.
  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && !rst) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant;
        grant1 = ~last_grant;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // The operation and operand registers are loaded on the grant edge and
  // cleared on the EXEC exit edge, so they are non-zero only during EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_onehot  <= '0;
      opnd1_q    <= '0;
      opnd2_q    <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            op_onehot  <= decode_op(grant1 ? req1_op : req0_op);
            opnd1_q    <= grant1 ? req1_operand_1 : req0_operand_1;
            opnd2_q    <= grant1 ? req1_operand_2 : req0_operand_2;
            rsp_id     <= grant1;
            last_grant <= grant1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_valid  <= 1'b1;
          op_onehot  <= '0;
          opnd1_q    <= '0;
          opnd2_q    <= '0;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign alu_operation_add                   = op_onehot[0];
  assign alu_operation_subtract              = op_onehot[1];
  assign alu_operation_and                   = op_onehot[2];
  assign alu_operation_or                    = op_onehot[3];
  assign alu_operation_xor                   = op_onehot[4];
  assign alu_operation_shift_left_logical    = op_onehot[5];
  assign alu_operation_shift_right_arithmetic = op_onehot[6];
  assign alu_operation_shift_right_logical   = op_onehot[7];
  assign alu_operand_1                       = opnd1_q;
  assign alu_operand_2                       = opnd2_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU, directed stimulus, scoreboard queue
// of hand-computed responses checked by an independent monitor process.

module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]  req0_op, req1_op;
  logic [31:0] req0_operand_1, req0_operand_2, req1_operand_1, req1_operand_2;
  logic        op_add, op_sub, op_and, op_or, op_xor, op_sll, op_sra, op_srl;
  logic [31:0] alu_operand_1, alu_operand_2, alu_result;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_result;
  logic [7:0]  alu_ops;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          hs_count = 0;
  int          cyc      = 0;
  logic [32:0] exp_q[$];
  logic [32:0] mon_e;

  alu_arbiter #(.X_LEN(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_operand_1(req0_operand_1), .req0_operand_2(req0_operand_2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_operand_1(req1_operand_1), .req1_operand_2(req1_operand_2),
    .alu_operation_add(op_add), .alu_operation_subtract(op_sub),
    .alu_operation_and(op_and), .alu_operation_or(op_or),
    .alu_operation_xor(op_xor), .alu_operation_shift_left_logical(op_sll),
    .alu_operation_shift_right_arithmetic(op_sra),
    .alu_operation_shift_right_logical(op_srl),
    .alu_operand_1(alu_operand_1), .alu_operand_2(alu_operand_2),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign alu_ops = {op_srl, op_sra, op_sll, op_xor, op_or, op_and, op_sub, op_add};

  // Environment ALU
  always_comb begin
    alu_result = '0;
    if (op_add)      alu_result = alu_operand_1 + alu_operand_2;
    else if (op_sub) alu_result = alu_operand_1 - alu_operand_2;
    else if (op_and) alu_result = alu_operand_1 & alu_operand_2;
    else if (op_or)  alu_result = alu_operand_1 | alu_operand_2;
    else if (op_xor) alu_result = alu_operand_1 ^ alu_operand_2;
    else if (op_sll) alu_result = alu_operand_1 << alu_operand_2[4:0];
    else if (op_sra) alu_result = $unsigned($signed(alu_operand_1) >>> alu_operand_2[4:0]);
    else if (op_srl) alu_result = alu_operand_1 >> alu_operand_2[4:0];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (req0_ready || req1_ready)
      check("one_ready", 32'(req0_ready & req1_ready), 32'd0);
    if (!rst && rsp_valid && rsp_ready) begin
      hs_count++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_rsp: got id=%0d result=0x%08h expected no response",
                 rsp_id, rsp_result);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(mon_e[32]));
        check("rsp_result", rsp_result, mon_e[31:0]);
      end
    end
  end

  task automatic issue(input logic id, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    int t;
    if (id) begin
      req1_op = op; req1_operand_1 = a; req1_operand_2 = b; req1_valid = 1'b1;
    end else begin
      req0_op = op; req0_operand_1 = a; req0_operand_2 = b; req0_valid = 1'b1;
    end
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(id ? req1_ready : req0_ready) && t < 50);
    check(id ? "grant1" : "grant0", 32'(id ? req1_ready : req0_ready), 32'd1);
    @(posedge clk); #1;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_alu_idle(input string name);
    check({name, "_ops"}, 32'(alu_ops), 32'd0);
    check({name, "_opnd1"}, alu_operand_1, 32'd0);
    check({name, "_opnd2"}, alu_operand_2, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int t, g, hs0;
    int gc[6];
    rst = 1'b1; rsp_ready = 1'b1;
    req1_valid = 1'b0; req1_op = '0; req1_operand_1 = '0; req1_operand_2 = '0;
    // Test 1: reset values, then single req0 add 8,16
    req0_valid = 1'b1; req0_op = 3'd0; req0_operand_1 = 32'd8; req0_operand_2 = 32'd16;
    repeat (2) @(negedge clk);
    check("rst_ready0", 32'(req0_ready), 32'd0);
    check_alu_idle("rst_alu");
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_result", rsp_result, 32'd0);
    exp_q.push_back({1'b0, 32'd24});
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("grant_ready0", 32'(req0_ready), 32'd1);
    @(posedge clk); #1 req0_valid = 1'b0;
    @(negedge clk);
    check("exec_ops", 32'(alu_ops), 32'h01);
    check("exec_opnd1", alu_operand_1, 32'd8);
    check("exec_opnd2", alu_operand_2, 32'd16);
    @(negedge clk);
    check("resp_valid_lat", 32'(rsp_valid), 32'd1);
    check_alu_idle("resp_alu");
    wait_drain();

    // Test 2: tie (last grant was req0 -> req0 wins only because reset set 1? no:
    // last_grant is now 0, so a tie goes to req1) -- keep the reset-tie for
    // test 6; here the tie runs from the post-reset single grant.
    // Re-establish reset state so the tie follows the reset rule.
    rst = 1'b1; #2 rst = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back({1'b0, 32'h18});
    exp_q.push_back({1'b1, 32'h8});
    req0_op = 3'd1; req0_operand_1 = 32'd8;        req0_operand_2 = 32'hFFFF_FFF0;
    req1_op = 3'd4; req1_operand_1 = 32'hFFFF_FFF8; req1_operand_2 = 32'hFFFF_FFF0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    check("tie_ready0", 32'(req0_ready), 32'd1);
    check("tie_ready1", 32'(req1_ready), 32'd0);
    @(posedge clk); #1 req0_valid = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!req1_ready && t < 50);
    check("tie_grant1", 32'(req1_ready), 32'd1);
    @(posedge clk); #1 req1_valid = 1'b0;
    wait_drain();

    // Test 3: fairness, both continuously valid
    for (int k = 0; k < 6; k++)
      exp_q.push_back((k % 2) ? {1'b1, 32'h30} : {1'b0, 32'd3});
    req0_op = 3'd0; req0_operand_1 = 32'd1;   req0_operand_2 = 32'd2;
    req1_op = 3'd2; req1_operand_1 = 32'hF0;  req1_operand_2 = 32'h3C;
    req0_valid = 1'b1; req1_valid = 1'b1;
    g = 0; t = 0;
    while (g < 6 && t < 200) begin
      @(negedge clk);
      t++;
      if (req0_ready || req1_ready) begin
        gc[g] = cyc;
        g++;
      end
    end
    check("fair_grants", 32'(g), 32'd6);
    @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 1; i < 6; i++)
      check("fair_spacing", 32'(gc[i] - gc[i-1]), 32'd3);
    wait_drain();

    // Test 4: backpressure
    rsp_ready = 1'b0;
    exp_q.push_back({1'b0, 32'd6});
    issue(1'b0, 3'd4, 32'd5, 32'd3);
    t = 0;
    do begin @(negedge clk); t++; end while (!rsp_valid && t < 50);
    check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    @(posedge clk); #1;
    exp_q.push_back({1'b1, 32'd101});
    req1_op = 3'd0; req1_operand_1 = 32'd100; req1_operand_2 = 32'd1; req1_valid = 1'b1;
    hs0 = hs_count;
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_id", 32'(rsp_id), 32'd0);
      check("bp_result", rsp_result, 32'd6);
      check("bp_ready1", 32'(req1_ready), 32'd0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!req1_ready && t < 50);
    check("bp_grant1", 32'(req1_ready), 32'd1);
    check("bp_after_hs", 32'(hs_count - hs0), 32'd1);
    @(posedge clk); #1 req1_valid = 1'b0;
    wait_drain();

    // Test 5: shifts via req1
    exp_q.push_back({1'b1, 32'hFFFF_FFFE});
    issue(1'b1, 3'd6, 32'hFFFF_FFE0, 32'd4);
    exp_q.push_back({1'b1, 32'h0FFF_FFFE});
    issue(1'b1, 3'd7, 32'hFFFF_FFE0, 32'd4);
    exp_q.push_back({1'b1, 32'hFFFF_FF80});
    issue(1'b1, 3'd5, 32'hFFFF_FFF8, 32'd4);
    wait_drain();

    // Test 6: reset mid-EXEC. last_grant is 1 here, so the tie goes to req0,
    // which leaves last_grant 0; only reset can make the next tie go to req0.
    req0_op = 3'd0; req0_operand_1 = 32'd1; req0_operand_2 = 32'd1;
    req1_op = 3'd0; req1_operand_1 = 32'd2; req1_operand_2 = 32'd2;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    check("pre_rst_ready0", 32'(req0_ready), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_exec", 32'(alu_ops), 32'h01);
    #1 rst = 1'b1;
    #1;
    check_alu_idle("mid_rst_alu");
    check("mid_rst_ready0", 32'(req0_ready), 32'd0);
    check("mid_rst_ready1", 32'(req1_ready), 32'd0);
    @(negedge clk);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    exp_q.push_back({1'b0, 32'd2});
    exp_q.push_back({1'b1, 32'd4});
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready0", 32'(req0_ready), 32'd1);
    check("post_rst_ready1", 32'(req1_ready), 32'd0);
    check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1 req0_valid = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!req1_ready && t < 50);
    check("post_rst_grant1", 32'(req1_ready), 32'd1);
    @(posedge clk); #1 req1_valid = 1'b0;
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
